// File: rtl/shuffle_sched_pkg.sv
// Shared types, constants and the round-robin search helper for the
// shuffle scheduler.
package shuffle_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,  // output register empty
    FULL = 1'b1   // output register holds an unconsumed result
  } state_t;

  localparam int SHUF_W  = 4;
  localparam int MAX_REQ = 16;

  // Return the index of the first set bit of req at or after ptr, wrapping
  // at nreq-1 -> 0. Callers zero-extend narrower vectors to MAX_REQ bits.
  // If no bit is set the result is ptr; callers qualify with |req.
  function automatic logic [3:0] rr_next(input logic [3:0]         ptr,
                                         input logic [MAX_REQ-1:0] req,
                                         input logic [4:0]         nreq);
    logic [4:0] idx;
    logic       found;
    logic [3:0] g;
    g     = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (5'(i) < nreq) && req[idx[3:0]]) begin
        found = 1'b1;
        g     = idx[3:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/shuffle_rr_scheduler_shuf.sv
// Catalog 4-bit bit-shuffle element: c = {a[0], b[2], a[1], b[3]}.
module shuffle_rr_scheduler_shuf
  import shuffle_sched_pkg::*;
(
  input  logic [SHUF_W-1:0] a,
  input  logic [SHUF_W-1:0] b,
  output logic [SHUF_W-1:0] c
);

  assign c = {a[0], b[2], a[1], b[3]};

endmodule

// File: rtl/shuffle_rr_scheduler.sv
// Round-robin scheduler sharing one shuffle element among NREQ requesters,
// with a single-entry output register tagged by requester id.
//
// Handshake semantics: a transfer happens on a rising clk edge where both
// valid and ready are high. req_ready is combinational from req_valid and
// rsp_ready, so requesters must not derive req_valid from req_ready; they
// hold req_valid/req_a/req_b stable until accepted. rsp_data/rsp_id stay
// stable while rsp_valid is high and rsp_ready is low.
module shuffle_rr_scheduler
  import shuffle_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int CNTW = 16,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*SHUF_W-1:0] req_a,
  input  logic [NREQ*SHUF_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [SHUF_W-1:0]      rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic [CNTW-1:0]        op_count
);

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [SHUF_W-1:0]  data_q, data_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;

  logic [MAX_REQ-1:0] req_pad;
  logic [3:0]         ptr_ext;
  logic [3:0]         grant4;
  logic [IDW-1:0]     grant;
  logic               any_req;
  logic               can_accept;
  logic               drain;
  logic               accept;
  logic [SHUF_W-1:0]  a_sel, b_sel, shuf_c;

  // Round-robin search from the pointer over the request vector.
  always_comb begin
    req_pad             = '0;
    req_pad[NREQ-1:0]   = req_valid;
    ptr_ext             = '0;
    ptr_ext[IDW-1:0]    = ptr_q;
    grant4              = rr_next(ptr_ext, req_pad, 5'(NREQ));
    grant               = IDW'(grant4);
    any_req             = |req_valid;
  end

  assign rsp_valid  = (state_q == FULL);
  assign drain      = rsp_valid && rsp_ready;
  // A full register can take a new result in the same cycle it drains.
  assign can_accept = (state_q == IDLE) || drain;

  // One-hot accept strobe to the winner; forced low while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && any_req && can_accept) req_ready[grant] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);
  assign a_sel  = req_a[grant*SHUF_W +: SHUF_W];
  assign b_sel  = req_b[grant*SHUF_W +: SHUF_W];

  shuffle_rr_scheduler_shuf u_shuf (
    .a (a_sel),
    .b (b_sel),
    .c (shuf_c)
  );

  // FSM next state, output register load, pointer advance and drain count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = FULL;
      data_d  = shuf_c;
      id_d    = grant;
      ptr_d   = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end else if (drain) begin
      state_d = IDLE;
    end
    if (drain) cnt_d = cnt_q + 1'b1;
  end

  // State and datapath registers; reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_data = data_q;
  assign rsp_id   = id_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_shuffle_rr_scheduler.sv
// Directed bench for shuffle_rr_scheduler: the driver pushes hand-computed
// {id, data} responses into exp_q; the monitor pops on each consumed result.
module tb_shuffle_rr_scheduler;

  localparam int NREQ = 4;
  localparam int CNTW = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*4-1:0] req_a = '0;
  logic [NREQ*4-1:0] req_b = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [3:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic [CNTW-1:0]   op_count;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [IDW+3:0]    exp_q[$];
  logic [IDW+3:0]    mon_e;

  // Per-requester results for the fairness operands, computed by hand:
  // r0 A=1 B=C -> D, r1 A=A B=6 -> 6, r2 A=F B=0 -> A, r3 A=0 B=F -> 5.
  logic [3:0]        fair_exp [4] = '{4'hD, 4'h6, 4'hA, 4'h5};

  shuffle_rr_scheduler #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  task automatic push_exp(input logic [IDW-1:0] id, input logic [3:0] data);
    exp_q.push_back({id, data});
  endtask

  // Monitor: inputs change just after posedge, so valid&&ready seen at the
  // falling edge is exactly the handshake of the next rising edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d data=0x%0h, expected no response", rsp_id, rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_sb", 32'({rsp_id, rsp_data}), 32'(mon_e));
      end
    end
  end

  // Driver
  initial begin
    // 1. Reset with random inputs
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = 16'($urandom_range(0, 65535));
      req_b     = 16'($urandom_range(0, 65535));
      rsp_ready = 1'($urandom_range(0, 1));
      tick();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
    end
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id",   32'(rsp_id),   32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 3. Fairness: all requesting, grants 0,1,2,3,0,1
    set_op(0, 4'h1, 4'hC);
    set_op(1, 4'hA, 4'h6);
    set_op(2, 4'hF, 4'h0);
    set_op(3, 4'h0, 4'hF);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k > 0) chk("fair_rsp_valid", 32'(rsp_valid), 32'd1);
      push_exp(IDW'(k % 4), fair_exp[k % 4]);
      tick();
    end
    req_valid = '0;
    tick();
    #1;
    chk("fair_op_count", 32'(op_count), 32'd6);
    chk("fair_idle", 32'(rsp_valid), 32'd0);

    // 2. Single request on requester 2 (pointer is at 2)
    set_op(2, 4'hA, 4'h6);
    req_valid = 4'b0100;
    #1;
    chk("single_grant", 32'(req_ready), 32'b0100);
    push_exp(2'd2, 4'h6);
    tick();
    req_valid = '0;
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_data",  32'(rsp_data),  32'h6);
    chk("single_rsp_id",    32'(rsp_id),    32'd2);
    chk("single_cnt_t1",    32'(op_count),  32'd6);
    tick();
    #1;
    chk("single_cnt_t2",    32'(op_count),  32'd7);
    chk("single_idle",      32'(rsp_valid), 32'd0);

    // 4. Backpressure: A=F B=0 on requester 2 -> A, held 5 cycles
    rsp_ready = 1'b0;
    set_op(2, 4'hF, 4'h0);
    req_valid = 4'b0100;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b0100);
    push_exp(2'd2, 4'hA);
    tick();
    req_valid = 4'b1000;   // requester 3 waits: A=0 B=F -> 5
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data",  32'(rsp_data),  32'hA);
      chk("bp_no_ready",   32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_drain_accept", 32'(req_ready), 32'b1000);
    push_exp(2'd3, 4'h5);
    tick();
    req_valid = '0;
    #1;
    chk("bp_new_data", 32'(rsp_data), 32'h5);
    chk("bp_new_id",   32'(rsp_id),   32'd3);
    chk("bp_cnt",      32'(op_count), 32'd8);
    tick();
    #1;
    chk("bp_cnt2",     32'(op_count), 32'd9);

    // 5. Pointer skip / wrap (pointer at 0, then 1)
    set_op(0, 4'h1, 4'hC);
    set_op(3, 4'h1, 4'hC);
    req_valid = 4'b0001;
    #1;
    chk("skip_grant0a", 32'(req_ready), 32'b0001);
    push_exp(2'd0, 4'hD);
    tick();
    #1;
    chk("skip_grant0b", 32'(req_ready), 32'b0001);
    push_exp(2'd0, 4'hD);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("skip_grant3", 32'(req_ready), 32'b1000);
    push_exp(2'd3, 4'hD);
    tick();
    req_valid = '0;
    #1;
    chk("skip_rsp_id",   32'(rsp_id),   32'd3);
    chk("skip_rsp_data", 32'(rsp_data), 32'hD);
    tick();
    #1;
    chk("skip_cnt", 32'(op_count), 32'd12);

    // 6. Asynchronous reset while holding a result
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1;
    chk("mid_rsp_valid_pre", 32'(rsp_valid), 32'd1);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rsp_data",  32'(rsp_data),  32'd0);
    chk("async_rsp_id",    32'(rsp_id),    32'd0);
    chk("async_op_count",  32'(op_count),  32'd0);
    chk("async_req_ready", 32'(req_ready), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'b0001);
    push_exp(2'd0, 4'hD);
    tick();
    req_valid = '0;

    // Bounded wait for all expected responses to be consumed.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("final_cnt", 32'(op_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
